// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared DM arbiter types and defaults
// Purpose: FSM state encoding, default parameter values and a width helper
//          shared by dm_arbiter and dm_arb_satctr.
// Ports:   none (package).
package dm_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } arb_state_t;

  localparam int          STARVE_MAX_DEF = 4;
  localparam logic [31:0] DBG_PC_DEF     = 32'h0000_0000;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int satctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dm_arb_satctr.sv
// rtl/dm_arb_satctr.sv - saturating up-counter with synchronous clear
// Purpose: counts up on inc, holds at MAX, returns to zero on clr or reset.
// Ports:   clk, reset (sync, active-high), clr, inc -> cnt [W-1:0].
module dm_arb_satctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_W)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data memory arbiter between Mem stage and debug port
// Purpose: the Mem stage owns DM with zero added latency; the debug port is
//          granted when the CPU is idle, or forced in with a one-cycle CPU
//          stall once dbg_req has waited STARVE_MAX CPU-won cycles.
// Ports:   clk, reset (sync, active-high)
//          cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_pc in, cpu_rdata/cpu_stall out
//          dbg_req/dbg_we/dbg_addr/dbg_wdata in, dbg_ack/dbg_rdata out
//          dm_addr/dm_wdata/dm_we/dm_pc out, dm_rdata in
//          stall_cnt out (only when DM_ARB_STATS_EN is defined)
// Config:  DM_ARB_STATS_EN adds the cumulative stall counter.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int          STARVE_MAX = STARVE_MAX_DEF,
  parameter logic [31:0] DBG_PC     = DBG_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int SW = satctr_width(STARVE_MAX);

  arb_state_t    state;
  logic [SW-1:0] starve;
  logic          starve_full;
  logic          grant_dbg;
  logic          starve_inc;
  logic          starve_clr;

  assign starve_full = (starve == SW'(STARVE_MAX));
  assign grant_dbg   = (state == ST_IDLE) && dbg_req && (!cpu_req || starve_full);
  assign cpu_stall   = grant_dbg && cpu_req;
  assign cpu_rdata   = dm_rdata;

  // Count only cycles the CPU actually beat a waiting debug request.
  assign starve_inc = (state == ST_IDLE) && dbg_req && cpu_req && !grant_dbg;
  assign starve_clr = grant_dbg || !dbg_req;

  dm_arb_satctr #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .cnt   (starve)
  );

  // A stalled CPU access is simply not presented to DM; the Mem stage
  // re-presents it next cycle.
  always_comb begin
    dm_addr  = cpu_addr;
    dm_wdata = cpu_wdata;
    dm_we    = cpu_req && cpu_we;
    dm_pc    = cpu_pc;
    if (grant_dbg) begin
      dm_addr  = dbg_addr;
      dm_wdata = dbg_wdata;
      dm_we    = dbg_we;
      dm_pc    = DBG_PC;
    end
  end

  // ACK always lasts exactly one cycle, so grants are at least two apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= grant_dbg;
      state   <= grant_dbg ? ST_ACK : ST_IDLE;
      if (grant_dbg) begin
        dbg_rdata <= dm_rdata;
      end
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cpu_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
module tb_dm_arbiter;

  localparam int          SMAX = 4;
  localparam logic [31:0] DPC  = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        dm_we;
`ifdef DM_ARB_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_MAX(SMAX), .DBG_PC(DPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_pc    (cpu_pc),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_rdata  (dm_rdata)
`ifdef DM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Data memory: combinational read, write at the clock edge.
  logic        mem_clear;
  logic [31:0] dm_mem [64];
  assign dm_rdata = dm_mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) dm_mem[i] <= 32'd0;
    end else if (dm_we) begin
      dm_mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: a debug request wins when nothing is being acknowledged
  // and either the CPU is idle or it has already won SMAX waiting cycles.
  bit          m_ack;
  int          m_wait;
  logic [31:0] m_rd;
  logic [31:0] m_scnt;
  logic [31:0] ref_mem [64];
  bit          e_grant;

  task automatic model_check();
    e_grant = !m_ack && dbg_req && (!cpu_req || m_wait >= SMAX);
    chk("m_stall", 32'(cpu_stall), 32'(e_grant && cpu_req));
    chk("m_dm_we", 32'(dm_we), 32'(e_grant ? dbg_we : (cpu_req && cpu_we)));
    chk("m_dm_addr", dm_addr, e_grant ? dbg_addr : cpu_addr);
    chk("m_dm_wdata", dm_wdata, e_grant ? dbg_wdata : cpu_wdata);
    chk("m_dm_pc", dm_pc, e_grant ? DPC : cpu_pc);
    chk("m_dbg_ack", 32'(dbg_ack), 32'(m_ack));
    chk("m_dbg_rdata", dbg_rdata, m_rd);
    if (!e_grant && cpu_req && !cpu_we) chk("m_cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);
`ifdef DM_ARB_STATS_EN
    chk("m_stall_cnt", stall_cnt, m_scnt);
`endif
  endtask

  task automatic model_update();
    if (e_grant) begin
      m_rd = ref_mem[dbg_addr[7:2]];
      if (dbg_we) ref_mem[dbg_addr[7:2]] = dbg_wdata;
    end else if (cpu_req && cpu_we) begin
      ref_mem[cpu_addr[7:2]] = cpu_wdata;
    end
    if (e_grant && cpu_req) m_scnt = m_scnt + 32'd1;
    if (e_grant || !dbg_req) m_wait = 0;
    else if (!m_ack && cpu_req && m_wait < SMAX) m_wait++;
    m_ack = e_grant;
    if (reset) begin
      m_ack = 0; m_wait = 0; m_rd = 32'd0; m_scnt = 32'd0;
    end
  endtask

  task automatic tick_pre();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick_post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    tick_pre();
    tick_post();
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_pc = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        x_stall, x_we;
    logic [31:0] x_addr, x_pc;
    logic        x_ack;
    logic [31:0] x_drd, x_crd;
  } vec_t;

  vec_t tv[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1; mem_clear = 1;
    m_ack = 0; m_wait = 0; m_rd = 0; m_scnt = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    #1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 0; mem_clear = 0;

    // Reset state
    @(negedge clk);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
`ifdef DM_ARB_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    model_check();
    tick_post();

    // Directed single-cycle vectors; cpu_pc = 0x400 + 4*i
    tv[0] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'h10, 32'h400, 1'b0, 32'h0,         32'h0};
    tv[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h10, 32'h404, 1'b0, 32'h0,         32'hDEAD_BEEF};
    tv[2] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h10, 32'h0,  1'b0, 1'b0, 32'h10, DPC,     1'b0, 32'h0,         32'h0};
    tv[3] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h40C, 1'b1, 32'hDEAD_BEEF, 32'h0};
    tv[4] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h410, 1'b0, 32'hDEAD_BEEF, 32'h0};
    tv[5] = '{1'b1, 1'b1, 32'h14, 32'h1234,      1'b1, 1'b1, 32'h18, 32'h55, 1'b0, 1'b1, 32'h14, 32'h414, 1'b0, 32'hDEAD_BEEF, 32'h0};
    tv[6] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h18, 32'h55, 1'b0, 1'b1, 32'h18, DPC,     1'b0, 32'hDEAD_BEEF, 32'h0};
    tv[7] = '{1'b1, 1'b0, 32'h18, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h18, 32'h41C, 1'b1, 32'h0,         32'h55};
    tv[8] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h14, 32'h0,  1'b0, 1'b0, 32'h14, DPC,     1'b0, 32'h0,         32'h0};
    tv[9] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,  32'h424, 1'b1, 32'h1234,      32'h0};

    for (int i = 0; i < 10; i++) begin
      cpu_req = tv[i].cr; cpu_we = tv[i].cw; cpu_addr = tv[i].ca; cpu_wdata = tv[i].cd;
      cpu_pc = 32'h400 + 32'(4 * i);
      dbg_req = tv[i].dr; dbg_we = tv[i].dw; dbg_addr = tv[i].da; dbg_wdata = tv[i].dd;
      tick_pre();
      chk($sformatf("tv%0d_stall", i), 32'(cpu_stall), 32'(tv[i].x_stall));
      chk($sformatf("tv%0d_dm_we", i), 32'(dm_we), 32'(tv[i].x_we));
      chk($sformatf("tv%0d_dm_addr", i), dm_addr, tv[i].x_addr);
      chk($sformatf("tv%0d_dm_pc", i), dm_pc, tv[i].x_pc);
      chk($sformatf("tv%0d_dbg_ack", i), 32'(dbg_ack), 32'(tv[i].x_ack));
      chk($sformatf("tv%0d_dbg_rdata", i), dbg_rdata, tv[i].x_drd);
      if (tv[i].cr && !tv[i].cw) chk($sformatf("tv%0d_cpu_rdata", i), cpu_rdata, tv[i].x_crd);
      tick_post();
    end

    // Starvation with colliding writes to 0x20: debug writes 1, CPU writes 2
    for (int k = 0; k < 6; k++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'd2; cpu_pc = 32'h500 + 32'(k);
      dbg_req = (k < 5); dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'd1;
      tick_pre();
      chk($sformatf("starve_stall_t%0d", k), 32'(cpu_stall), 32'(k == SMAX));
      chk($sformatf("starve_ack_t%0d", k), 32'(dbg_ack), 32'(k == SMAX + 1));
      if (k == SMAX) chk("starve_dm_wdata_grant", dm_wdata, 32'd1);
      if (k == SMAX + 1) chk("starve_dm_wdata_retry", dm_wdata, 32'd2);
      tick_post();
      if (k == SMAX) chk("mem_after_grant", dm_mem[8], 32'd1);
      if (k == SMAX + 1) chk("mem_after_retry", dm_mem[8], 32'd2);
    end

    // Reset in the ACK cycle
    idle_inputs();
    dbg_req = 1; dbg_addr = 32'h20;
    cycle();
    dbg_req = 0; reset = 1;
    tick_pre();
    chk("pre_rst_ack", 32'(dbg_ack), 32'd1);
    tick_post();
    reset = 0;
    cpu_req = 1; cpu_addr = 32'h20; dbg_req = 1; dbg_addr = 32'h14;
    tick_pre();
    chk("rst_ack_dropped", 32'(dbg_ack), 32'd0);
    chk("rst_rdata_clear", dbg_rdata, 32'd0);
    chk("rst_starve_zero", 32'(cpu_stall), 32'd0);
`ifdef DM_ARB_STATS_EN
    chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
`endif
    tick_post();
    idle_inputs();
    cycle();

`ifdef DM_ARB_STATS_EN
    // Three forced grants
    for (int g = 0; g < 3; g++) begin
      cpu_req = 1; cpu_addr = 32'h4 * g; dbg_req = 1; dbg_addr = 32'h10;
      repeat (SMAX + 1) cycle();
      dbg_req = 0;
      cycle();
    end
    cpu_req = 0;
    tick_pre();
    chk("stats_three_grants", stall_cnt, 32'd3);
    tick_post();
`endif

    // Randomized traffic under the debug handshake rules
    begin
      bit pend = 0;
      for (int n = 0; n < 3000; n++) begin
        cpu_req   = ($urandom_range(3) != 0);
        cpu_we    = $urandom_range(1) != 0;
        cpu_addr  = 32'($urandom_range(15)) << 2;
        cpu_wdata = $urandom;
        cpu_pc    = $urandom;
        if (m_ack) begin
          pend = 0;
          dbg_req = $urandom_range(1) != 0;
          dbg_we = $urandom_range(1) != 0;
          dbg_addr = 32'($urandom_range(15)) << 2;
          dbg_wdata = $urandom;
        end else if (!pend) begin
          if ($urandom_range(2) == 0) begin
            pend = 1;
            dbg_req = 1;
            dbg_we = $urandom_range(1) != 0;
            dbg_addr = 32'($urandom_range(15)) << 2;
            dbg_wdata = $urandom;
          end else begin
            dbg_req = 0;
          end
        end
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
